// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine
//   Byte-substitution engine. Accepts a 128-bit state, substitutes LANES bytes
//   per clock, working from byte 0 ([127:120]) towards byte 15. The finished
//   block is held on out_state until the consumer accepts it.
//
//   Parameters
//     LANES     bytes substituted per cycle (1, 2, 4, 8, 16)
//     FWD_FILE  forward table file name (kept for compatibility)
//     INV_FILE  inverse table file name (kept for compatibility)
//
//   Configuration macro
//     SUB_BYTES_ENGINE_FWD_EN  defined  : forward and inverse tables, in_mode selects
//                              undefined: inverse table only, in_mode ignored
//
//   Ports
//     clk        rising-edge clock
//     reset_n    synchronous active-low reset
//     in_valid   in_state/in_mode valid
//     in_ready   engine idle, block can be accepted
//     in_state   input state, byte 0 at [127:120]
//     in_mode    0 = forward S-box, 1 = inverse S-box
//     out_valid  out_state holds a finished block
//     out_ready  consumer accepts out_state
//     out_state  working register (valid when out_valid=1)
//     busy       block in progress or awaiting acceptance
module sub_bytes_engine #(
   parameter int unsigned LANES    = 4,
   parameter              FWD_FILE = "sbox.txt",
   parameter              INV_FILE = "invsbox.txt"
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic         in_mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   typedef logic [255:0][7:0] rom_t;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   // Table contents are generated at elaboration by constant functions over
   // GF(2^8), so no external file is read; the names are only sanity-checked.
   if (FWD_FILE == "" || INV_FILE == "") begin : g_bad_file_param
      $error("sub_bytes_engine: ROM file name parameters must be non-empty");
   end

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
   end

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 == x^-1 in GF(2^8); 0 maps to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] r;
      sq = x;
      r  = 8'h01;
      for (int unsigned i = 0; i < 7; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
             {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic rom_t gen_fwd_rom();
      rom_t t;
      for (int unsigned i = 0; i < 256; i++) begin
         t[8'(i)] = affine(gf_inv(8'(i)));
      end
      return t;
   endfunction

   function automatic rom_t gen_inv_rom();
      rom_t f;
      rom_t t;
      f = gen_fwd_rom();
      t = '0;
      for (int unsigned i = 0; i < 256; i++) begin
         t[f[8'(i)]] = 8'(i);
      end
      return t;
   endfunction

`ifdef SUB_BYTES_ENGINE_FWD_EN
   localparam rom_t FWD_ROM = gen_fwd_rom();
`endif
   localparam rom_t INV_ROM = gen_inv_rom();

   // Byte k of the state lives at packed index 15-k, so byte 0 is [127:120].
   function automatic logic [3:0] lane_pos(input logic [3:0] base, input int unsigned lane);
      return 4'd15 - base - 4'(lane);
   endfunction

   state_e             fsm_q;
   logic [4:0]         cnt_q;
   logic [4:0]         cnt_d;
   logic               mode_q;
   logic [15:0][7:0]   st_q;
   logic [15:0][7:0]   st_sub_d;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               busy_q;

`ifndef SUB_BYTES_ENGINE_FWD_EN
   logic unused_mode;
   assign unused_mode = mode_q;
`endif

   assign cnt_d = cnt_q + 5'(LANES);

   // LANES parallel table reads on the bytes at counter .. counter+LANES-1.
   always_comb begin
      st_sub_d = st_q;
      for (int unsigned l = 0; l < LANES; l++) begin
`ifdef SUB_BYTES_ENGINE_FWD_EN
         st_sub_d[lane_pos(cnt_q[3:0], l)] = mode_q ? INV_ROM[st_q[lane_pos(cnt_q[3:0], l)]]
                                                    : FWD_ROM[st_q[lane_pos(cnt_q[3:0], l)]];
`else
         st_sub_d[lane_pos(cnt_q[3:0], l)] = INV_ROM[st_q[lane_pos(cnt_q[3:0], l)]];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fsm_q       <= IDLE;
         cnt_q       <= '0;
         mode_q      <= 1'b0;
         st_q        <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (in_valid) begin
                  st_q       <= in_state;
                  mode_q     <= in_mode;
                  cnt_q      <= '0;
                  fsm_q      <= BUSY;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            BUSY: begin
               st_q  <= st_sub_d;
               cnt_q <= cnt_d;
               if (cnt_d == 5'd16) begin
                  fsm_q       <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  fsm_q       <= IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               fsm_q       <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_state = st_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
module tb_sub_bytes_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset_n;
   logic [127:0] in_state;
   logic         in_mode;

   logic         in_valid4, in_ready4, out_valid4, out_ready4, busy4;
   logic [127:0] out_state4;
   logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
   logic [127:0] out_state1;
   logic         in_valid16, in_ready16, out_valid16, out_ready16, busy16;
   logic [127:0] out_state16;

   sub_bytes_engine #(.LANES(4)) u_dut4 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .in_state(in_state), .in_mode(in_mode), .out_valid(out_valid4),
      .out_ready(out_ready4), .out_state(out_state4), .busy(busy4));

   sub_bytes_engine #(.LANES(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_state(in_state), .in_mode(in_mode), .out_valid(out_valid1),
      .out_ready(out_ready1), .out_state(out_state1), .busy(busy1));

   sub_bytes_engine #(.LANES(16)) u_dut16 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid16), .in_ready(in_ready16),
      .in_state(in_state), .in_mode(in_mode), .out_valid(out_valid16),
      .out_ready(out_ready16), .out_state(out_state16), .busy(busy16));

   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Reference tables built from the field definition: inverse by exhaustive
   // search, affine transform bit by bit.
   logic [7:0] m_fwd [256];
   logic [7:0] m_inv [256];

   function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
      for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   task automatic build_tables();
      logic [7:0] c;
      logic [7:0] xv, iv, s;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         xv = 8'(x);
         iv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul_ref(xv, 8'(y)) == 8'h01) iv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = iv[i] ^ iv[(i+4)%8] ^ iv[(i+5)%8] ^ iv[(i+6)%8] ^ iv[(i+7)%8] ^ c[i];
         m_fwd[x] = s;
         m_inv[s] = xv;
      end
   endtask

   function automatic logic [127:0] sub_model(input logic [127:0] st, input logic md);
      logic [127:0] r;
      logic [7:0]   b;
      logic         use_inv;
`ifdef SUB_BYTES_ENGINE_FWD_EN
      use_inv = md;
`else
      use_inv = md | 1'b1;
`endif
      r = '0;
      for (int k = 0; k < 16; k++) begin
         b = st[127-8*k -: 8];
         r[127-8*k -: 8] = use_inv ? m_inv[b] : m_fwd[b];
      end
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One block through the LANES=4 engine, consumer stalls for 'hold' cycles.
   task automatic run4(input logic [127:0] st, input logic md, input int hold,
                       output logic [127:0] got);
      int lat;
      check_eq("in_ready4_idle", 128'(in_ready4), 128'(1));
      in_state  = st;
      in_mode   = md;
      in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      in_state  = rand128();
      in_mode   = 1'($urandom);
      check_eq("busy4_after_accept", 128'({busy4, in_ready4}), 128'(2'b10));
      lat = 0;
      while (!out_valid4 && lat < 40) begin
         tick();
         lat++;
      end
      check_eq("latency4", 128'(lat), 128'(4));
      got = out_state4;
      check_eq("data4", out_state4, sub_model(st, md));
      repeat (hold) begin
         tick();
         check_eq("hold_stable4", out_state4, got);
         check_eq("hold_valid4", 128'(out_valid4), 128'(1));
      end
      out_ready4 = 1'b1;
      tick();
      out_ready4 = 1'b0;
      check_eq("release4", 128'({in_ready4, out_valid4, busy4}), 128'(3'b100));
   endtask

   task automatic run_pair(input logic [127:0] st, input logic md);
      int lat1, lat16;
      logic [127:0] d1, d16;
      lat1 = -1; lat16 = -1; d1 = '0; d16 = '0;
      check_eq("pair_ready", 128'({in_ready1, in_ready16}), 128'(2'b11));
      in_state   = st;
      in_mode    = md;
      in_valid1  = 1'b1;
      in_valid16 = 1'b1;
      tick();
      in_valid1  = 1'b0;
      in_valid16 = 1'b0;
      in_state   = rand128();
      for (int t = 1; t <= 30 && (lat1 < 0 || lat16 < 0); t++) begin
         tick();
         if (out_valid1 && lat1 < 0) begin lat1 = t; d1 = out_state1; end
         if (out_valid16 && lat16 < 0) begin lat16 = t; d16 = out_state16; end
      end
      check_eq("latency1", 128'(lat1), 128'(16));
      check_eq("latency16", 128'(lat16), 128'(1));
      check_eq("data1", d1, sub_model(st, md));
      check_eq("data16", d16, sub_model(st, md));
      check_eq("data1_vs_16", out_state1, out_state16);
      out_ready1  = 1'b1;
      out_ready16 = 1'b1;
      tick();
      out_ready1  = 1'b0;
      out_ready16 = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [127:0] got, cap, blk_b;
      logic         mode_b;
      int           first, second;
      bit           saw;

      build_tables();
      reset_n = 1'b0;
      in_state = rand128(); in_mode = 1'b0;
      in_valid4 = 1'b0; out_ready4 = 1'b0;
      in_valid1 = 1'b0; out_ready1 = 1'b0;
      in_valid16 = 1'b0; out_ready16 = 1'b0;
      tick();
      tick();
      check_eq("reset_flags4", 128'({in_ready4, out_valid4, busy4}), 128'(3'b100));
      check_eq("reset_state4", out_state4, 128'h0);
      check_eq("reset_flags1_16", 128'({in_ready1, out_valid1, in_ready16, out_valid16}), 128'(4'b1010));

      // First block accepted on the very first edge out of reset.
      reset_n = 1'b1;
`ifdef SUB_BYTES_ENGINE_FWD_EN
      run4(128'h0, 1'b0, 2, got);
      check_eq("kat_fwd_zero", got, {16{8'h63}});
`else
      run4({16{8'h63}}, 1'b0, 2, got);
      check_eq("kat_inv_only", got, 128'h0);
`endif
      run4({16{8'h63}}, 1'b1, 0, got);
      check_eq("kat_inv_63", got, 128'h0);
      run4({16{8'hed}}, 1'b1, 1, got);
      check_eq("kat_inv_ed", got, {16{8'h53}});

      for (int i = 0; i < 20; i++)
         run4(rand128(), 1'($urandom_range(0, 1)), $urandom_range(0, 3), got);

      // Stall in DONE while a new block is offered.
      in_state = rand128(); in_mode = 1'($urandom);
      cap = sub_model(in_state, in_mode);
      in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      for (int t = 0; t < 40 && !out_valid4; t++) tick();
      check_eq("stall_data", out_state4, cap);
      blk_b = rand128(); mode_b = 1'($urandom);
      in_state = blk_b; in_mode = mode_b; in_valid4 = 1'b1;
      for (int t = 0; t < 10; t++) begin
         tick();
         check_eq("stall_stable", out_state4, cap);
         check_eq("stall_flags", 128'({in_ready4, out_valid4}), 128'(2'b01));
      end
      out_ready4 = 1'b1;
      tick();
      out_ready4 = 1'b0;
      check_eq("stall_release", 128'({in_ready4, out_valid4}), 128'(2'b10));
      run4(blk_b, mode_b, 0, got);

      // Back-to-back throughput with the consumer always ready.
      in_state = rand128(); in_mode = 1'($urandom);
      in_valid4 = 1'b1; out_ready4 = 1'b1;
      first = -1; second = -1;
      for (int t = 0; t < 60 && second < 0; t++) begin
         tick();
         if (out_valid4) begin
            if (first < 0) first = t;
            else second = t;
         end
      end
      check_eq("throughput", 128'(second - first), 128'(6));
      in_valid4 = 1'b0;
      repeat (10) tick();
      out_ready4 = 1'b0;
      check_eq("throughput_idle", 128'(in_ready4), 128'(1));

      // Reset in the second BUSY cycle aborts the block.
      in_state = rand128(); in_mode = 1'($urandom);
      in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check_eq("abort_flags", 128'({in_ready4, out_valid4, busy4}), 128'(3'b100));
      check_eq("abort_state", out_state4, 128'h0);
      saw = 1'b0;
      for (int t = 0; t < 20; t++) begin
         tick();
         if (out_valid4) saw = 1'b1;
      end
      check_eq("abort_no_done", 128'(saw), 128'(0));
      run4(rand128(), 1'($urandom), 0, got);

      // Same stimulus through LANES=1 and LANES=16.
      run_pair({16{8'h00}}, 1'b0);
      for (int i = 0; i < 4; i++) run_pair(rand128(), 1'($urandom_range(0, 1)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
